// File: rtl/fac8_0_pair_buffer.sv
// Pairs each second-half beat of a 512-point frame with the beat 256 indices earlier.
// Produces the add/sub stage inputs, its -j select, frame markers and a framing error pulse.
module fac8_0_pair_buffer #(
    parameter int WIDTH      = 9,
    parameter int DATA_WIDTH = 16,
    parameter int HALF_BEATS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sop,
    input  logic signed [WIDTH-1:0] din_re            [0:DATA_WIDTH-1],
    input  logic signed [WIDTH-1:0] din_im            [0:DATA_WIDTH-1],
    output logic signed [WIDTH-1:0] dout_re           [0:DATA_WIDTH-1],
    output logic signed [WIDTH-1:0] dout_im           [0:DATA_WIDTH-1],
    output logic signed [WIDTH-1:0] dout_shift_reg_re [0:DATA_WIDTH-1],
    output logic signed [WIDTH-1:0] dout_shift_reg_im [0:DATA_WIDTH-1],
    output logic                    fac8_0_cal,
    output logic                    out_valid,
    output logic                    out_eop,
    output logic                    sop_err
);
    localparam int CW = $clog2(2 * HALF_BEATS);
    localparam logic [CW-1:0] LAST_FILL = CW'(HALF_BEATS - 1);
    localparam logic [CW-1:0] LAST_PAIR = CW'(2 * HALF_BEATS - 1);

    typedef enum logic [1:0] {IDLE, FILL, PAIR} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   pos;
    logic            beat;
    logic            pair_beat;
    logic            early_sop;

    logic signed [WIDTH-1:0] dl_re [0:HALF_BEATS-1][0:DATA_WIDTH-1];
    logic signed [WIDTH-1:0] dl_im [0:HALF_BEATS-1][0:DATA_WIDTH-1];

    // In IDLE only an in_sop beat is accepted; everything else is dropped silently.
    assign beat      = in_valid && ((state != IDLE) || in_sop);
    assign pos       = in_sop ? '0 : cnt;
    assign pair_beat = beat && (state == PAIR) && !in_sop;
    assign early_sop = beat && in_sop && (state != IDLE) && (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            out_valid  <= 1'b0;
            fac8_0_cal <= 1'b0;
            out_eop    <= 1'b0;
            sop_err    <= 1'b0;
        end else begin
            out_valid  <= pair_beat;
            // Upper quarter of the frame (pos 24..31) takes the -j twiddle.
            fac8_0_cal <= pair_beat && pos[CW-2];
            out_eop    <= pair_beat && (pos == LAST_PAIR);
            sop_err    <= early_sop;
            if (beat) begin
                cnt <= pos + 1'b1;
                if (pos == LAST_FILL)
                    state <= PAIR;
                else if (pos == LAST_PAIR || in_sop)
                    state <= FILL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < HALF_BEATS; s++) begin
                for (int l = 0; l < DATA_WIDTH; l++) begin
                    dl_re[s][l] <= '0;
                    dl_im[s][l] <= '0;
                end
            end
            for (int l = 0; l < DATA_WIDTH; l++) begin
                dout_re[l]           <= '0;
                dout_im[l]           <= '0;
                dout_shift_reg_re[l] <= '0;
                dout_shift_reg_im[l] <= '0;
            end
        end else begin
            if (pair_beat) begin
                for (int l = 0; l < DATA_WIDTH; l++) begin
                    dout_re[l]           <= din_re[l];
                    dout_im[l]           <= din_im[l];
                    dout_shift_reg_re[l] <= dl_re[HALF_BEATS-1][l];
                    dout_shift_reg_im[l] <= dl_im[HALF_BEATS-1][l];
                end
            end
            // Head of the line is the beat accepted exactly HALF_BEATS beats ago.
            if (beat) begin
                for (int l = 0; l < DATA_WIDTH; l++) begin
                    dl_re[0][l] <= din_re[l];
                    dl_im[0][l] <= din_im[l];
                end
                for (int s = 1; s < HALF_BEATS; s++) begin
                    for (int l = 0; l < DATA_WIDTH; l++) begin
                        dl_re[s][l] <= dl_re[s-1][l];
                        dl_im[s][l] <= dl_im[s-1][l];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fac8_0_pair_buffer.sv
// Bench for fac8_0_pair_buffer: directed vector table, then scenario and random stimulus
// checked against a position-indexed frame model.
module tb_fac8_0_pair_buffer;
    localparam int W = 9;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_sop = 1'b0;
    logic signed [W-1:0] din_re [0:N-1];
    logic signed [W-1:0] din_im [0:N-1];
    logic signed [W-1:0] dout_re [0:N-1];
    logic signed [W-1:0] dout_im [0:N-1];
    logic signed [W-1:0] dout_shift_reg_re [0:N-1];
    logic signed [W-1:0] dout_shift_reg_im [0:N-1];
    logic fac8_0_cal, out_valid, out_eop, sop_err;

    always #5 clk = ~clk;

    fac8_0_pair_buffer #(.WIDTH(W), .DATA_WIDTH(N), .HALF_BEATS(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
        .din_re(din_re), .din_im(din_im),
        .dout_re(dout_re), .dout_im(dout_im),
        .dout_shift_reg_re(dout_shift_reg_re), .dout_shift_reg_im(dout_shift_reg_im),
        .fac8_0_cal(fac8_0_cal), .out_valid(out_valid), .out_eop(out_eop), .sop_err(sop_err)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_valid_seen = 0;
    int n_err_seen = 0;

    // Reference model: frame beats stored by position, pairs looked up as pos-16.
    bit m_active;
    int m_next;
    logic signed [W-1:0] m_mem_re [0:31][0:N-1];
    logic signed [W-1:0] m_mem_im [0:31][0:N-1];
    logic signed [W-1:0] e_re [0:N-1];
    logic signed [W-1:0] e_im [0:N-1];
    logic signed [W-1:0] e_sh_re [0:N-1];
    logic signed [W-1:0] e_sh_im [0:N-1];
    bit e_valid, e_cal, e_eop, e_err;

    typedef struct {
        bit valid; bit sop; int b;
        bit ev; bit ec; bit ee; bit ld; int er; int es;
    } vec_t;
    vec_t tbl [0:32];

    task automatic chk(input string name, input bit ok, input int got, input int want);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    endtask

    task automatic model_reset();
        m_active = 0;
        m_next = 0;
        {e_valid, e_cal, e_eop, e_err} = 4'b0;
        for (int l = 0; l < N; l++) begin
            e_re[l] = '0; e_im[l] = '0; e_sh_re[l] = '0; e_sh_im[l] = '0;
        end
    endtask

    task automatic model_beat();
        int p;
        {e_valid, e_cal, e_eop, e_err} = 4'b0;
        if (in_valid && (m_active || in_sop)) begin
            p = in_sop ? 0 : m_next;
            e_err = in_sop && m_active && (m_next != 0);
            if (p >= 16 && !in_sop) begin
                e_valid = 1;
                e_cal = (p >= 24);
                e_eop = (p == 31);
                for (int l = 0; l < N; l++) begin
                    e_re[l] = din_re[l]; e_im[l] = din_im[l];
                    e_sh_re[l] = m_mem_re[p-16][l]; e_sh_im[l] = m_mem_im[p-16][l];
                end
            end
            for (int l = 0; l < N; l++) begin
                m_mem_re[p][l] = din_re[l];
                m_mem_im[p][l] = din_im[l];
            end
            m_active = 1;
            m_next = (p + 1) % 32;
        end
    endtask

    task automatic check_flags(input string name);
        chk({name, "_flags"}, {out_valid, fac8_0_cal, out_eop, sop_err} == {e_valid, e_cal, e_eop, e_err},
            int'({out_valid, fac8_0_cal, out_eop, sop_err}), int'({e_valid, e_cal, e_eop, e_err}));
    endtask

    task automatic check_data(input string name);
        int bad;
        bad = -1;
        for (int l = N - 1; l >= 0; l--) begin
            if (dout_re[l] !== e_re[l] || dout_im[l] !== e_im[l] ||
                dout_shift_reg_re[l] !== e_sh_re[l] || dout_shift_reg_im[l] !== e_sh_im[l]) bad = l;
        end
        if (bad < 0) chk({name, "_data"}, 1'b1, 0, 0);
        else chk($sformatf("%s_data lane%0d re/sh_re", name, bad), 1'b0,
                 int'(dout_re[bad]) * 1000 + int'(dout_shift_reg_re[bad]),
                 int'(e_re[bad]) * 1000 + int'(e_sh_re[bad]));
    endtask

    task automatic step(input bit v, input bit s, input string name);
        in_valid = v;
        in_sop = s;
        model_beat();
        @(posedge clk);
        #1;
        if (out_valid) n_valid_seen++;
        if (sop_err) n_err_seen++;
        check_flags(name);
        check_data(name);
        $display("step %s v=%0b sop=%0b -> valid=%0b cal=%0b eop=%0b err=%0b re0=%0d sh0=%0d",
                 name, v, s, out_valid, fac8_0_cal, out_eop, sop_err, dout_re[0], dout_shift_reg_re[0]);
    endtask

    task automatic set_lin(input int base);
        for (int l = 0; l < N; l++) begin
            din_re[l] = W'(base + l);
            din_im[l] = W'(-(base + l));
        end
    endtask

    task automatic set_ext();
        for (int l = 0; l < N; l++) begin
            din_re[l] = (l % 2 == 0) ? -9'sd256 : 9'sd255;
            din_im[l] = (l % 2 == 0) ? 9'sd255 : -9'sd256;
        end
    endtask

    task automatic set_rand();
        logic [31:0] r;
        for (int l = 0; l < N; l++) begin
            r = $urandom;
            din_re[l] = r[W-1:0];
            din_im[l] = r[W+8:9];
        end
    endtask

    task automatic run_frame(input int base, input bit with_sop, input string name);
        for (int b = 0; b < 32; b++) begin
            set_lin(base + b);
            step(1'b1, with_sop && b == 0, name);
        end
    endtask

    initial begin
        int v0, e0;
        set_lin(0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_flags("reset");
        check_data("reset");
        rst = 1'b0;

        // Directed table: single frame, lane l re = b+l, im = -(b+l).
        for (int i = 0; i < 32; i++) begin
            tbl[i].valid = 1; tbl[i].sop = (i == 0); tbl[i].b = i;
            tbl[i].ev = (i >= 16); tbl[i].ec = (i >= 24); tbl[i].ee = (i == 31);
            tbl[i].ld = (i >= 16); tbl[i].er = (i >= 16) ? i : 0; tbl[i].es = (i >= 16) ? i - 16 : 0;
        end
        tbl[32].valid = 0; tbl[32].sop = 0; tbl[32].b = 99;
        tbl[32].ev = 0; tbl[32].ec = 0; tbl[32].ee = 0;
        tbl[32].ld = 1; tbl[32].er = 31; tbl[32].es = 15;

        for (int i = 0; i < 33; i++) begin
            int bad_l;
            in_valid = tbl[i].valid;
            in_sop = tbl[i].sop;
            set_lin(tbl[i].b);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_flags", i),
                {out_valid, fac8_0_cal, out_eop, sop_err} == {tbl[i].ev, tbl[i].ec, tbl[i].ee, 1'b0},
                int'({out_valid, fac8_0_cal, out_eop, sop_err}), int'({tbl[i].ev, tbl[i].ec, tbl[i].ee, 1'b0}));
            bad_l = -1;
            for (int l = N - 1; l >= 0; l--) begin
                int xr, xs;
                xr = tbl[i].ld ? tbl[i].er + l : 0;
                xs = tbl[i].ld ? tbl[i].es + l : 0;
                if (int'(dout_re[l]) != xr || int'(dout_im[l]) != -xr ||
                    int'(dout_shift_reg_re[l]) != xs || int'(dout_shift_reg_im[l]) != -xs) bad_l = l;
            end
            v0 = (bad_l < 0) ? 0 : int'(dout_re[bad_l]) * 1000 + int'(dout_shift_reg_re[bad_l]);
            e0 = (bad_l < 0) ? 0 : (tbl[i].ld ? (tbl[i].er + bad_l) * 1000 + tbl[i].es + bad_l : 0);
            chk($sformatf("tbl%0d_data lane%0d", i, bad_l), bad_l < 0, v0, e0);
            $display("tbl %0d b=%0d -> valid=%0b cal=%0b eop=%0b re0=%0d sh0=%0d",
                     i, tbl[i].b, out_valid, fac8_0_cal, out_eop, dout_re[0], dout_shift_reg_re[0]);
        end

        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();

        // in_valid gaps after beats 5 and 20
        n_valid_seen = 0;
        for (int b = 0; b < 32; b++) begin
            set_lin(b);
            step(1'b1, b == 0, "gap");
            if (b == 5 || b == 20) begin
                for (int g = 0; g < 3; g++) begin
                    set_lin(77);
                    step(1'b0, 1'b0, "gap_idle");
                end
            end
        end
        set_lin(0);
        step(1'b0, 1'b0, "gap_tail");
        chk("gap_valid_count", n_valid_seen == 16, n_valid_seen, 16);

        // back-to-back frames, second without sop
        n_err_seen = 0;
        run_frame(0, 1'b1, "b2b_f1");
        run_frame(100, 1'b0, "b2b_f2");
        chk("b2b_no_err", n_err_seen == 0, n_err_seen, 0);

        // full-scale extremes
        set_ext();
        for (int b = 0; b < 32; b++) step(1'b1, b == 0, "ext");

        // early sop at beat 10
        n_err_seen = 0;
        for (int b = 0; b < 10; b++) begin
            set_lin(b);
            step(1'b1, b == 0, "early_old");
        end
        set_lin(50);
        step(1'b1, 1'b1, "early_sop");
        for (int b = 1; b < 32; b++) begin
            set_lin(50 + b);
            step(1'b1, 1'b0, "early_new");
        end
        chk("early_err_count", n_err_seen == 1, n_err_seen, 1);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            set_rand();
            step($urandom_range(0, 4) != 0, $urandom_range(0, 19) == 0, "rand");
        end

        // reset mid-PAIR, then a fresh frame
        for (int b = 0; b < 21; b++) begin
            set_lin(b);
            step(1'b1, b == 0, "pre_rst");
        end
        rst = 1'b1;
        #2;
        model_reset();
        check_flags("rst_mid");
        check_data("rst_mid");
        rst = 1'b0;
        run_frame(0, 1'b1, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
